// File: rtl/pipe_dbg_pkg.sv
// Shared types for the pipeline state-dump responder.
// Holds the FSM state enum, out_kind codes and the default word width.
package pipe_dbg_pkg;

   localparam int XLEN_DEF = 64;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRAIN,
      S_REGS,
      S_MEM,
      S_FLUSH,
      S_DONE
   } state_t;

   localparam logic [1:0] KIND_REG  = 2'b00;
   localparam logic [1:0] KIND_MEM  = 2'b01;
   localparam logic [1:0] KIND_CSUM = 2'b10;

endpackage

// File: rtl/pipe_dump_outreg.sv
// Single-entry output holding register for the dump stream.
// Ports: load/clear control, in_* payload, valid/data/kind/index/last held.
module pipe_dump_outreg #(
   parameter int XLEN = 64,
   parameter int IW   = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            clear,
   input  logic [XLEN-1:0] in_data,
   input  logic [1:0]      in_kind,
   input  logic [IW-1:0]   in_index,
   input  logic            in_last,
   output logic            valid,
   output logic [XLEN-1:0] data,
   output logic [1:0]      kind,
   output logic [IW-1:0]   index,
   output logic            last
);

   // load wins over clear: an accepted beat is replaced in the same cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         kind  <= '0;
         index <= '0;
         last  <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= in_data;
         kind  <= in_kind;
         index <= in_index;
         last  <= in_last;
      end else if (clear) begin
         valid <= 1'b0;
         last  <= 1'b0;
      end
   end

endmodule

// File: rtl/pipe_state_dump.sv
// Halts the core, drains the pipe, then streams x0..x31 and a datamem window.
// Ports: dump_req/mem_base/mem_count start, halt, rf/dm debug reads, out_* stream, busy/done.
// Option: PIPE_STATE_DUMP_CHECKSUM_EN appends an XOR checksum beat.
module pipe_state_dump
   import pipe_dbg_pkg::*;
#(
   parameter int XLEN         = XLEN_DEF,
   parameter int NUM_REGS     = 32,
   parameter int MEM_ADDR_W   = 10,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  dump_req,
   input  logic [MEM_ADDR_W-1:0] mem_base,
   input  logic [MEM_ADDR_W:0]   mem_count,
   output logic                  halt,
   output logic [4:0]            rf_rd_addr,
   input  logic [XLEN-1:0]       rf_rd_data,
   output logic [MEM_ADDR_W-1:0] dm_rd_addr,
   input  logic [XLEN-1:0]       dm_rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_data,
   output logic [1:0]            out_kind,
   output logic [MEM_ADDR_W-1:0] out_index,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = MEM_ADDR_W + 1;
   localparam logic [CW-1:0] MAX_CNT  = {1'b1, {MEM_ADDR_W{1'b0}}};
   localparam logic [CW-1:0] LAST_REG = CW'(NUM_REGS - 1);
   localparam logic [7:0]    DRAIN_N  = 8'(DRAIN_CYCLES);
`ifdef PIPE_STATE_DUMP_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   state_t                state;
   logic [7:0]            drain_cnt;
   logic [CW-1:0]         idx;
   logic [CW-1:0]         cnt;
   logic [MEM_ADDR_W-1:0] base;
`ifdef PIPE_STATE_DUMP_CHECKSUM_EN
   logic [XLEN-1:0]       csum;
   logic                  csum_done;
`endif

   logic                  room;
   logic                  ld;
   logic                  clr;
   logic [XLEN-1:0]       ld_data;
   logic [1:0]            ld_kind;
   logic [MEM_ADDR_W-1:0] ld_index;
   logic                  ld_last;

   assign rf_rd_addr = idx[4:0];
   assign dm_rd_addr = base + idx[MEM_ADDR_W-1:0];
   assign room       = !out_valid || out_ready;

   always_comb begin
      ld       = 1'b0;
      clr      = 1'b0;
      ld_data  = '0;
      ld_kind  = KIND_REG;
      ld_index = '0;
      ld_last  = 1'b0;
      case (state)
         S_REGS: begin
            ld       = room;
            // x0 is hardwired zero whatever the read port returns
            ld_data  = (idx == '0) ? '0 : rf_rd_data;
            ld_index = idx[MEM_ADDR_W-1:0];
            ld_last  = !CSUM && idx == LAST_REG && cnt == '0;
         end
         S_MEM: begin
            ld       = room;
            ld_data  = dm_rd_data;
            ld_kind  = KIND_MEM;
            ld_index = dm_rd_addr;
            ld_last  = !CSUM && idx == cnt - CW'(1);
         end
         S_FLUSH: begin
`ifdef PIPE_STATE_DUMP_CHECKSUM_EN
            if (!csum_done) begin
               ld      = room;
               ld_data = csum;
               ld_kind = KIND_CSUM;
               ld_last = 1'b1;
            end else begin
               clr = out_valid && out_ready;
            end
`else
            clr = out_valid && out_ready;
`endif
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         halt      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         drain_cnt <= '0;
         idx       <= '0;
         cnt       <= '0;
         base      <= '0;
`ifdef PIPE_STATE_DUMP_CHECKSUM_EN
         csum      <= '0;
         csum_done <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (dump_req) begin
                  base      <= mem_base;
                  cnt       <= (mem_count > MAX_CNT) ? MAX_CNT : mem_count;
                  halt      <= 1'b1;
                  busy      <= 1'b1;
                  drain_cnt <= '0;
                  idx       <= '0;
`ifdef PIPE_STATE_DUMP_CHECKSUM_EN
                  csum      <= '0;
                  csum_done <= 1'b0;
`endif
                  state     <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (drain_cnt == DRAIN_N) state <= S_REGS;
               else drain_cnt <= drain_cnt + 8'd1;
            end
            S_REGS: begin
               if (ld) begin
`ifdef PIPE_STATE_DUMP_CHECKSUM_EN
                  csum <= csum ^ ld_data;
`endif
                  if (idx == LAST_REG) begin
                     idx   <= '0;
                     state <= (cnt == '0) ? S_FLUSH : S_MEM;
                  end else begin
                     idx <= idx + CW'(1);
                  end
               end
            end
            S_MEM: begin
               if (ld) begin
`ifdef PIPE_STATE_DUMP_CHECKSUM_EN
                  csum <= csum ^ ld_data;
`endif
                  if (idx == cnt - CW'(1)) state <= S_FLUSH;
                  else idx <= idx + CW'(1);
               end
            end
            S_FLUSH: begin
`ifdef PIPE_STATE_DUMP_CHECKSUM_EN
               if (ld) csum_done <= 1'b1;
`endif
               if (clr) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               halt  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   pipe_dump_outreg #(
      .XLEN (XLEN),
      .IW   (MEM_ADDR_W)
   ) u_outreg (
      .clk      (clk),
      .rst      (reset),
      .load     (ld),
      .clear    (clr),
      .in_data  (ld_data),
      .in_kind  (ld_kind),
      .in_index (ld_index),
      .in_last  (ld_last),
      .valid    (out_valid),
      .data     (out_data),
      .kind     (out_kind),
      .index    (out_index),
      .last     (out_last)
   );

endmodule

// File: tb/tb_pipe_state_dump.sv
// Self-checking bench for pipe_state_dump against a beat-list reference model.
// Build with +define+PIPE_STATE_DUMP_CHECKSUM_EN to cover the checksum beat.
module tb_pipe_state_dump;

   localparam int XLEN  = 64;
   localparam int AW    = 10;
   localparam int DRAIN = 4;
   localparam int DEPTH = 1 << AW;
`ifdef PIPE_STATE_DUMP_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic            dump_req;
   logic [AW-1:0]   mem_base;
   logic [AW:0]     mem_count;
   logic            halt;
   logic [4:0]      rf_rd_addr;
   logic [XLEN-1:0] rf_rd_data;
   logic [AW-1:0]   dm_rd_addr;
   logic [XLEN-1:0] dm_rd_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_data;
   logic [1:0]      out_kind;
   logic [AW-1:0]   out_index;
   logic            out_last;
   logic            busy;
   logic            done;

   logic [XLEN-1:0] rf [32];
   logic [XLEN-1:0] dm [DEPTH];
   logic [31:0]     pc;

   int vec  = 0;
   int errs = 0;

   typedef struct {
      logic [XLEN-1:0] d;
      logic [1:0]      k;
      logic [AW-1:0]   i;
      logic            l;
   } beat_t;

   beat_t expq[$];

   pipe_state_dump dut (
      .clk        (clk),
      .reset      (reset),
      .dump_req   (dump_req),
      .mem_base   (mem_base),
      .mem_count  (mem_count),
      .halt       (halt),
      .rf_rd_addr (rf_rd_addr),
      .rf_rd_data (rf_rd_data),
      .dm_rd_addr (dm_rd_addr),
      .dm_rd_data (dm_rd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_kind   (out_kind),
      .out_index  (out_index),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done)
   );

   assign rf_rd_data = rf[rf_rd_addr];
   assign dm_rd_data = dm[dm_rd_addr];

   always #5 clk = ~clk;

   // toy program: PC advances every cycle unless the core is halted
   always @(posedge clk) begin
      if (reset) pc <= 32'h0;
      else if (!halt) pc <= pc + 32'd4;
   end

   function automatic logic [XLEN-1:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   // expected stream: 32 regs, then the wrapped memory window, then checksum
   function automatic void build_model(input int base, input int cnt);
      int n;
      int total;
      int a;
      logic [XLEN-1:0] x;
      beat_t b;
      expq.delete();
      n = (cnt > DEPTH) ? DEPTH : cnt;
      total = 32 + n + CS;
      x = '0;
      for (int r = 0; r < 32; r++) begin
         b.d = (r == 0) ? '0 : rf[r];
         b.k = 2'b00;
         b.i = AW'(r);
         b.l = (expq.size() == total - 1);
         x ^= b.d;
         expq.push_back(b);
      end
      for (int j = 0; j < n; j++) begin
         a = (base + j) % DEPTH;
         b.d = dm[a];
         b.k = 2'b01;
         b.i = AW'(a);
         b.l = (expq.size() == total - 1);
         x ^= b.d;
         expq.push_back(b);
      end
      if (CS == 1) begin
         b.d = x;
         b.k = 2'b10;
         b.i = '0;
         b.l = 1'b1;
         expq.push_back(b);
      end
   endfunction

   // mode 0: ready always 1, mode 1: ready 1,0,0,1 repeating, mode 2: random
   task automatic run_dump(input int base, input int cnt, input int mode,
                           input bit hold_req, input string name);
      int    total;
      int    cyc;
      int    first;
      int    accepted;
      int    done_n;
      int    budget;
      bit    seen_done;
      bit    prev_v;
      bit    prev_r;
      beat_t pb;
      beat_t b;
      logic [31:0] pc_halt;
      logic [31:0] pc_done;
      build_model(base, cnt);
      total = expq.size();
      budget = total * 4 + 60;
      cyc = 0;
      first = -1;
      accepted = 0;
      done_n = 0;
      seen_done = 0;
      prev_v = 0;
      prev_r = 0;
      pc_halt = '0;
      pc_done = '0;
      pb = '{d: '0, k: '0, i: '0, l: 1'b0};
      @(negedge clk);
      dump_req  = 1'b1;
      mem_base  = AW'(base);
      mem_count = (AW + 1)'(cnt);
      out_ready = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            if (!hold_req) dump_req = 1'b0;
            pc_halt = pc;
            vec++;
            if (halt !== 1'b1 || busy !== 1'b1) begin
               errs++;
               $display("FAIL %s halt_on_req: halt=%b busy=%b want 1 1",
                        name, halt, busy);
            end
         end
         if (seen_done) begin
            vec++;
            if (done !== 1'b0 || halt !== 1'b0 || busy !== 1'b0) begin
               errs++;
               $display("FAIL %s release: done=%b halt=%b busy=%b want 0 0 0",
                        name, done, halt, busy);
            end
            break;
         end
         if (halt !== 1'b1) begin
            vec++;
            errs++;
            $display("FAIL %s halt_held: halt=%b want 1 at cycle %0d",
                     name, halt, cyc);
         end
         if (prev_v && !prev_r) begin
            vec++;
            if (out_valid !== 1'b1 || out_data !== pb.d || out_kind !== pb.k ||
                out_index !== pb.i || out_last !== pb.l) begin
               errs++;
               $display("FAIL %s stall_hold: got v=%b d=%h k=%b i=%0d l=%b want v=1 d=%h k=%b i=%0d l=%b",
                        name, out_valid, out_data, out_kind, out_index, out_last,
                        pb.d, pb.k, pb.i, pb.l);
            end
         end
         if (out_valid === 1'b1 && first < 0) begin
            first = cyc - 1;
            vec++;
            if (first != DRAIN + 2) begin
               errs++;
               $display("FAIL %s latency: got %0d want %0d", name, first, DRAIN + 2);
            end
         end
         if (mode == 0 && accepted > 0 && accepted < total) begin
            vec++;
            if (out_valid !== 1'b1) begin
               errs++;
               $display("FAIL %s gap: out_valid=%b want 1 after %0d beats",
                        name, out_valid, accepted);
            end
         end
         if (done === 1'b1) begin
            done_n++;
            seen_done = 1;
            pc_done = pc;
            vec++;
            if (accepted != total || expq.size() != 0) begin
               errs++;
               $display("FAIL %s done_count: got %0d beats want %0d",
                        name, accepted, total);
            end
         end
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = (cyc % 4 == 1) || (cyc % 4 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            vec++;
            if (expq.size() == 0) begin
               errs++;
               $display("FAIL %s extra_beat: got d=%h k=%b i=%0d want none",
                        name, out_data, out_kind, out_index);
            end else begin
               b = expq.pop_front();
               if (out_data !== b.d || out_kind !== b.k ||
                   out_index !== b.i || out_last !== b.l) begin
                  errs++;
                  $display("FAIL %s beat%0d: got d=%h k=%b i=%0d l=%b want d=%h k=%b i=%0d l=%b",
                           name, accepted, out_data, out_kind, out_index, out_last,
                           b.d, b.k, b.i, b.l);
               end
            end
            accepted++;
         end
         prev_v = (out_valid === 1'b1);
         prev_r = (out_ready === 1'b1);
         pb = '{d: out_data, k: out_kind, i: out_index, l: out_last};
         if (cyc > budget) begin
            vec++;
            errs++;
            $display("FAIL %s timeout: got %0d beats want %0d", name, accepted, total);
            break;
         end
      end
      dump_req  = 1'b0;
      out_ready = 1'b0;
      vec++;
      if (done_n != 1) begin
         errs++;
         $display("FAIL %s done_pulse: got %0d pulses want 1", name, done_n);
      end
      vec++;
      if (pc_done !== pc_halt) begin
         errs++;
         $display("FAIL %s pc_frozen: got %h want %h", name, pc_done, pc_halt);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      vec++;
      if (halt !== 0 || busy !== 0 || done !== 0 || out_valid !== 0 ||
          out_last !== 0) begin
         errs++;
         $display("FAIL reset_ctrl: halt=%b busy=%b done=%b v=%b l=%b want 0",
                  halt, busy, done, out_valid, out_last);
      end
      vec++;
      if (out_data !== '0 || out_kind !== '0 || out_index !== '0) begin
         errs++;
         $display("FAIL reset_payload: d=%h k=%b i=%0d want 0 0 0",
                  out_data, out_kind, out_index);
      end
      vec++;
      if (rf_rd_addr !== '0 || dm_rd_addr !== '0) begin
         errs++;
         $display("FAIL reset_addr: rf=%0d dm=%0d want 0 0", rf_rd_addr, dm_rd_addr);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      vec++;
      if (halt !== 1'b0) begin
         errs++;
         $display("FAIL idle_no_halt: halt=%b want 0", halt);
      end
   endtask

   task automatic test_regs_only();
      for (int r = 0; r < 32; r++) rf[r] = rnd64();
      rf[0] = 64'hDEAD_BEEF_0000_0001;
      rf[1] = 64'd5;
      rf[2] = 64'hA;
      run_dump($urandom_range(0, DEPTH - 1), 0, 0, 0, "regs_only");
   endtask

   task automatic test_mem_wrap();
      dm[1022] = 64'h11;
      dm[1023] = 64'h22;
      dm[0]    = 64'h33;
      dm[1]    = 64'h44;
      run_dump(1022, 4, 0, 0, "mem_wrap");
   endtask

   task automatic test_backpressure();
      run_dump($urandom_range(0, DEPTH - 1), 10, 1, 0, "bp_pattern");
      run_dump($urandom_range(0, DEPTH - 1), 13, 2, 0, "bp_random");
   endtask

   task automatic test_back_to_back();
      run_dump($urandom_range(0, DEPTH - 1), 3, 0, 1, "b2b_first");
      run_dump($urandom_range(0, DEPTH - 1), 5, 2, 0, "b2b_second");
   endtask

   task automatic test_clamp();
      run_dump($urandom_range(0, DEPTH - 1), 1500, 0, 0, "clamp");
   endtask

   task automatic test_reset_mid_dump();
      bit found;
      found = 0;
      @(negedge clk);
      dump_req  = 1'b1;
      mem_base  = AW'($urandom_range(0, DEPTH - 1));
      mem_count = 11'd50;
      out_ready = 1'b1;
      @(negedge clk);
      dump_req = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (out_valid === 1'b1 && out_kind === 2'b01) begin
            found = 1;
            break;
         end
      end
      vec++;
      if (!found) begin
         errs++;
         $display("FAIL rst_mid_reach_mem: got no mem beat want one");
      end
      #2;
      reset = 1'b1;
      #1;
      vec++;
      if (halt !== 0 || out_valid !== 0 || busy !== 0) begin
         errs++;
         $display("FAIL rst_mid_async: halt=%b v=%b busy=%b want 0 0 0",
                  halt, out_valid, busy);
      end
      out_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_dump($urandom_range(0, DEPTH - 1), 7, 2, 0, "after_reset");
   endtask

`ifdef PIPE_STATE_DUMP_CHECKSUM_EN
   task automatic test_checksum();
      for (int r = 0; r < 32; r++) rf[r] = '0;
      rf[1] = 64'd3;
      rf[2] = 64'd5;
      build_model(0, 0);
      vec++;
      if (expq.size() != 33 || expq[32].d !== 64'd6) begin
         errs++;
         $display("FAIL csum_model: size=%0d want 33", expq.size());
      end
      run_dump(0, 0, 1, 0, "checksum");
   endtask
`endif

   initial begin
      reset     = 1'b1;
      dump_req  = 1'b0;
      out_ready = 1'b0;
      mem_base  = '0;
      mem_count = '0;
      for (int r = 0; r < 32; r++) rf[r] = rnd64();
      for (int a = 0; a < DEPTH; a++) dm[a] = rnd64();
      test_reset();
      test_regs_only();
      test_mem_wrap();
      test_backpressure();
      test_back_to_back();
      test_clamp();
      test_reset_mid_dump();
`ifdef PIPE_STATE_DUMP_CHECKSUM_EN
      test_checksum();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
